neo_crom_splitter: RTL and testbench

Parametrised sprite-graphics burst splitter between the C-ROM/SDRAM read port and NEO-ZMC2. It buffers wide C-ROM bursts in a small FIFO and releases one CR_W-bit sub-word per LOAD strobe, in normal or h-flipped order chosen by CA4. It generalises the fixed two-half, unbuffered CR_DOUBLE split to N sub-words, adds buffering, handshake, flush and underflow reporting.

---
 rtl/neo_crom_pkg.sv | 24 ++
 rtl/neo_crom_splitter_if.sv | 21 ++
 rtl/neo_sync_fifo.sv | 72 +++++++
 rtl/neo_crom_splitter.sv | 142 ++++++++++++++
 tb/tb_neo_crom_splitter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/neo_crom_pkg.sv
// Shared constants and parameter helpers for the C-ROM burst splitter.
// Order encoding follows CA4: 1 walks sub-words upward, 0 walks them h-flipped.
package neo_crom_pkg;

  localparam logic ORD_NORMAL = 1'b1;
  localparam logic ORD_FLIP   = 1'b0;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit halves_ok(input int h);
    return is_pow2(h) && (h >= 2) && (h <= 4);
  endfunction

  function automatic bit depth_ok(input int d);
    return is_pow2(d) && (d >= 2) && (d <= 16);
  endfunction

endpackage

// File: rtl/neo_crom_splitter_if.sv
// Burst write port from the C-ROM/SDRAM reader into the splitter FIFO.
// BURST_READY is combinational from the stored level.
interface neo_crom_splitter_if #(
  parameter int W = 64
);
  logic [W-1:0] BURST_DATA;
  logic         BURST_VALID;
  logic         BURST_READY;

  modport master (
    output BURST_DATA,
    output BURST_VALID,
    input  BURST_READY
  );

  modport slave (
    input  BURST_DATA,
    input  BURST_VALID,
    output BURST_READY
  );
endinterface

// File: rtl/neo_sync_fifo.sv
// Single-clock FIFO with level output and synchronous clear.
// Storage is unreset; clear overrides push and pop in the same cycle.
module neo_sync_fifo
  import neo_crom_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = lvl_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic             do_push, do_pop;

  assign full_o  = (lvl_q == LW'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign level_o = lvl_q;
  assign rdata_o = mem_q[rd_q];

  assign do_push = push_i & ~full_o & ~clr_i;
  assign do_pop  = pop_i & ~empty_o & ~clr_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   lvl_d = lvl_q + LW'(1);
        2'b01:   lvl_d = lvl_q - LW'(1);
        default: lvl_d = lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/neo_crom_splitter.sv
// Buffers C-ROM bursts and hands one CR_W sub-word to ZMC2 per LOAD edge.
// Optional NEO_CROM_UF_COUNT_EN adds a saturating underflow counter on UF_COUNT.
module neo_crom_splitter
  import neo_crom_pkg::*;
#(
  parameter  int CR_W   = 32,
  parameter  int HALVES = 2,
  parameter  int DEPTH  = 4,
  localparam int LW     = lvl_w(DEPTH),
  localparam int IW     = $clog2(HALVES)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CLK_EN_24M,
  neo_crom_splitter_if.slave   burst,
  input  logic                 LOAD,
  input  logic                 CA4,
  input  logic                 FLUSH,
  output logic [CR_W-1:0]      CR,
  output logic                 CR_VALID,
  output logic [LW-1:0]        LEVEL,
  output logic                 UNDERFLOW,
  output logic [15:0]          UF_COUNT
);

  if (!halves_ok(HALVES)) begin : g_bad_halves
    $error("neo_crom_splitter: HALVES must be 2 or 4");
  end
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("neo_crom_splitter: DEPTH must be a power of 2 in 2..16");
  end

  logic [HALVES-1:0][CR_W-1:0] head;
  logic                        empty_w, full_w;
  logic                        edge_w, last_w, pop_w, uf_w, ord_w;
  logic [IW-1:0]               k_w;

  logic            lsr_q, lsr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            ord_q, ord_d;
  logic [CR_W-1:0] cr_q, cr_d;
  logic            vld_q, vld_d;
  logic            uf_q, uf_d;

  neo_sync_fifo #(
    .WIDTH (CR_W * HALVES),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .clr_i   (FLUSH),
    .push_i  (burst.BURST_VALID),
    .pop_i   (pop_w),
    .wdata_i (burst.BURST_DATA),
    .rdata_o (head),
    .level_o (LEVEL),
    .full_o  (full_w),
    .empty_o (empty_w)
  );

  assign burst.BURST_READY = ~full_w;

  assign edge_w = CLK_EN_24M & LOAD & ~lsr_q;
  assign last_w = (idx_q == IW'(HALVES - 1));
  // A fresh burst takes its order straight from CA4 on its first edge.
  assign ord_w  = (idx_q == '0) ? CA4 : ord_q;
  assign k_w    = (ord_w == ORD_NORMAL) ? idx_q
                                        : IW'(HALVES - 1) - idx_q;
  assign pop_w  = edge_w & ~empty_w & last_w & ~FLUSH;
  assign uf_w   = edge_w & empty_w & ~FLUSH;

  always_comb begin
    lsr_d = lsr_q;
    idx_d = idx_q;
    ord_d = ord_q;
    cr_d  = cr_q;
    vld_d = 1'b0;
    uf_d  = uf_q;
    if (FLUSH) begin
      lsr_d = 1'b0;
      idx_d = '0;
      ord_d = ORD_FLIP;
      cr_d  = '0;
      uf_d  = 1'b0;
    end else begin
      if (CLK_EN_24M) lsr_d = LOAD;
      if (edge_w) begin
        vld_d = 1'b1;
        if (idx_q == '0) ord_d = CA4;
        if (uf_w) begin
          cr_d = '0;
          uf_d = 1'b1;
        end else begin
          cr_d  = head[k_w];
          idx_d = last_w ? '0 : idx_q + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lsr_q <= 1'b0;
      idx_q <= '0;
      ord_q <= ORD_FLIP;
      cr_q  <= '0;
      vld_q <= 1'b0;
      uf_q  <= 1'b0;
    end else begin
      lsr_q <= lsr_d;
      idx_q <= idx_d;
      ord_q <= ord_d;
      cr_q  <= cr_d;
      vld_q <= vld_d;
      uf_q  <= uf_d;
    end
  end

  assign CR        = cr_q;
  assign CR_VALID  = vld_q;
  assign UNDERFLOW = uf_q;

`ifdef NEO_CROM_UF_COUNT_EN
  logic [15:0] ufc_q, ufc_d;

  // Survives FLUSH so software can read a per-frame total.
  always_comb begin
    ufc_d = ufc_q;
    if (uf_w && (ufc_q != 16'hFFFF)) ufc_d = ufc_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) ufc_q <= '0;
    else       ufc_q <= ufc_d;
  end

  assign UF_COUNT = ufc_q;
`else
  assign UF_COUNT = '0;
`endif

endmodule

// File: tb/tb_neo_crom_splitter.sv
// Self-checking bench: directed tables, corner sequences, random vs queue model.
module tb_neo_crom_splitter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, en, ld, ca, fl;
  logic [31:0] cr, cr4;
  logic        crv, crv4, uf, uf4;
  logic [2:0]  lvl;
  logic [1:0]  lvl4;
  logic [15:0] ufc, ufc4;

  neo_crom_splitter_if #(.W(64))  bif ();
  neo_crom_splitter_if #(.W(128)) b4 ();

  always #5 clk = ~clk;

  neo_crom_splitter #(.CR_W(32), .HALVES(2), .DEPTH(4)) dut (
    .CLK (clk), .RESET (rst), .CLK_EN_24M (en), .burst (bif.slave),
    .LOAD (ld), .CA4 (ca), .FLUSH (fl), .CR (cr), .CR_VALID (crv),
    .LEVEL (lvl), .UNDERFLOW (uf), .UF_COUNT (ufc)
  );

  neo_crom_splitter #(.CR_W(32), .HALVES(4), .DEPTH(2)) dut4 (
    .CLK (clk), .RESET (rst), .CLK_EN_24M (en), .burst (b4.slave),
    .LOAD (ld), .CA4 (ca), .FLUSH (fl), .CR (cr4), .CR_VALID (crv4),
    .LEVEL (lvl4), .UNDERFLOW (uf4), .UF_COUNT (ufc4)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: queue of stored bursts plus position inside the head.
  logic [63:0] m_q [$];
  int          m_pos;
  bit          m_ord, m_lsr, m_vld, m_uf;
  logic [31:0] m_cr;
  int          m_ufc;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic int ufc_exp(input int n);
`ifdef NEO_CROM_UF_COUNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pos = 0; m_ord = 0; m_lsr = 0; m_vld = 0;
    m_uf = 0; m_cr = '0; m_ufc = 0;
  endtask

  task automatic reset_all();
    rst = 1'b1; en = 0; ld = 0; ca = 0; fl = 0;
    bif.BURST_VALID = 0; bif.BURST_DATA = '0;
    b4.BURST_VALID = 0;  b4.BURST_DATA = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cr", cr, 0);
    chk("rst_crv", crv, 0);
    chk("rst_level", lvl, 0);
    chk("rst_ready", bif.BURST_READY, 1);
    chk("rst_uf", uf, 0);
    chk("rst_ufc", ufc, 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cyc(input bit e, input bit l, input bit c, input bit v,
                     input logic [63:0] d, input bit f);
    bit          acc, edg;
    int          k;
    logic [63:0] hd;
    en = e; ld = l; ca = c; fl = f;
    bif.BURST_VALID = v; bif.BURST_DATA = d;
    chk("ready", bif.BURST_READY, m_q.size() != DEPTH);
    acc   = v && (m_q.size() != DEPTH);
    edg   = e && l && !m_lsr;
    m_vld = 0;
    if (f) begin
      m_q.delete();
      m_pos = 0; m_ord = 0; m_lsr = 0; m_cr = '0; m_uf = 0;
    end else begin
      if (edg) begin
        if (m_pos == 0) m_ord = c;
        m_vld = 1;
        if (m_q.size() == 0) begin
          m_cr = '0;
          m_uf = 1;
          if (m_ufc < 65535) m_ufc++;
        end else begin
          hd = m_q[0];
          k = m_ord ? m_pos : 1 - m_pos;
          m_cr = hd[k*32 +: 32];
          m_pos++;
          if (m_pos == 2) begin
            m_pos = 0;
            void'(m_q.pop_front());
          end
        end
      end
      if (e) m_lsr = l;
      if (acc) m_q.push_back(d);
    end
    @(posedge clk);
    #1;
    chk("cr", cr, m_cr);
    chk("cr_valid", crv, m_vld);
    chk("level", lvl, m_q.size());
    chk("underflow", uf, m_uf);
    chk("uf_count", ufc, ufc_exp(m_ufc));
  endtask

  typedef struct {
    logic [63:0] d;
    bit          c0, c1;
    logic [31:0] e0, e1;
  } vec_t;

  task automatic c4(input bit l, input bit v, input logic [127:0] d);
    en = 1; ld = l; ca = 1; fl = 0;
    b4.BURST_VALID = v; b4.BURST_DATA = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        vt [4];
    int          pulses;
    logic [127:0] bb [4];

    vt[0] = '{64'hAAAA_BBBB_1111_2222, 1, 1, 32'h1111_2222, 32'hAAAA_BBBB};
    vt[1] = '{64'hAAAA_BBBB_1111_2222, 0, 1, 32'hAAAA_BBBB, 32'h1111_2222};
    vt[2] = '{64'h0123_4567_89AB_CDEF, 1, 0, 32'h89AB_CDEF, 32'h0123_4567};
    vt[3] = '{64'hDEAD_BEEF_CAFE_F00D, 0, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D};

    reset_all();

    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 1, vt[i].d, 0);
      chk("tbl_lvl_push", lvl, 1);
      cyc(1, 1, vt[i].c0, 0, '0, 0);
      chk("tbl_cr0", cr, vt[i].e0);
      chk("tbl_lvl_mid", lvl, 1);
      cyc(1, 0, 0, 0, '0, 0);
      cyc(1, 1, vt[i].c1, 0, '0, 0);
      chk("tbl_cr1", cr, vt[i].e1);
      chk("tbl_lvl_pop", lvl, 0);
      cyc(1, 0, 0, 0, '0, 0);
    end

    // Underflow on an empty FIFO, then a burst still starts at sub-word 0.
    cyc(1, 1, 1, 0, '0, 0);
    chk("uf_cr", cr, 0);
    chk("uf_crv", crv, 1);
    chk("uf_flag", uf, 1);
    chk("uf_cnt", ufc, ufc_exp(1));
    cyc(1, 0, 0, 1, 64'h5555_6666_7777_8888, 0);
    cyc(1, 1, 1, 0, '0, 0);
    chk("uf_next_sub0", cr, 32'h7777_8888);
    cyc(1, 0, 0, 0, '0, 0);
    cyc(0, 0, 0, 0, '0, 1);
    chk("flush_uf", uf, 0);
    chk("flush_ufc", ufc, ufc_exp(1));
    chk("flush_level", lvl, 0);

    // LOAD held high: one pulse; LOAD toggling with enable low: none.
    cyc(1, 0, 0, 1, 64'h9999_AAAA_BBBB_CCCC, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 1, 0, '0, 0);
      pulses += int'(crv);
    end
    chk("held_pulses", pulses, 1);
    cyc(1, 0, 0, 0, '0, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, i[0], 1, 0, '0, 0);
      pulses += int'(crv);
    end
    chk("noen_pulses", pulses, 0);
    cyc(1, 0, 0, 0, '0, 0);
    cyc(0, 0, 0, 0, '0, 1);

    // Reset after the first sub-word discards the partial burst.
    cyc(1, 0, 0, 1, 64'h1234_5678_9ABC_DEF0, 0);
    cyc(1, 1, 1, 0, '0, 0);
    chk("mid_sub0", cr, 32'h9ABC_DEF0);
    reset_all();
    cyc(1, 0, 0, 1, 64'h0F0F_0F0F_F0F0_F0F0, 0);
    cyc(1, 1, 1, 0, '0, 0);
    chk("post_rst_sub0", cr, 32'hF0F0_F0F0);
    cyc(1, 0, 0, 0, '0, 0);

    for (int n = 0; n < 800; n++) begin
      cyc(($urandom % 4) != 0, ($urandom % 3) == 0, $urandom % 2,
          $urandom % 2, {$urandom, $urandom}, ($urandom % 64) == 0);
    end

    // HALVES=4, DEPTH=2 instance.
    reset_all();
    for (int b = 0; b < 4; b++)
      bb[b] = {32'(8'hA3 + 16*b), 32'(8'hA2 + 16*b),
               32'(8'hA1 + 16*b), 32'(8'hA0 + 16*b)};
    chk("h4_ready0", b4.BURST_READY, 1);
    c4(0, 1, bb[0]);
    chk("h4_lvl1", lvl4, 1);
    c4(0, 1, bb[1]);
    chk("h4_lvl2", lvl4, 2);
    chk("h4_full", b4.BURST_READY, 0);
    c4(0, 1, bb[2]);
    chk("h4_stall_lvl", lvl4, 2);
    for (int i = 0; i < 4; i++) begin
      c4(1, 1, bb[2]);
      chk("h4_b0_cr", cr4, 32'hA0 + i);
      chk("h4_b0_crv", crv4, 1);
      chk("h4_b0_lvl", lvl4, (i == 3) ? 1 : 2);
      c4(0, 1, bb[2]);
      chk("h4_b0_lvl_lo", lvl4, 2);
    end
    for (int i = 0; i < 4; i++) begin
      c4(1, 0, '0);
      chk("h4_b1_cr", cr4, 32'hB0 + i);
      c4(0, 0, '0);
    end
    chk("h4_after_b1", lvl4, 1);
    for (int i = 0; i < 4; i++) begin
      c4(1, i == 3, bb[3]);
      chk("h4_b2_cr", cr4, 32'hC0 + i);
      chk("h4_b2_lvl", lvl4, 1);
      c4(0, 0, '0);
    end
    for (int i = 0; i < 4; i++) begin
      c4(1, 0, '0);
      chk("h4_b3_cr", cr4, 32'hD0 + i);
      c4(0, 0, '0);
    end
    chk("h4_empty", lvl4, 0);
    chk("h4_uf", uf4, 0);
    chk("h4_ufc", ufc4, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
